// File: rtl/truncador_pipe.sv
// ---------------------------------------------------------------------------
// truncador_pipe
//
// Pipelined fixed-point resize unit. Takes a wide signed sample (IN_W bits,
// IN_F fractional bits), drops SHIFT = IN_F - OUT_F fractional bits with
// either floor truncation or round-half-up, and clips the result into a signed
// OUT_W-bit word (OUT_F fractional bits). Clipping is reported on sat_hi /
// sat_lo. The two register stages form an elastic 2-entry pipeline with
// valid/ready handshakes on both sides.
//
// Optional feature macro: TRUNC_SATCNT_EN
//   When defined, adds a CNT_W-bit saturation event counter (sat_count) with
//   a synchronous clear (cnt_clr). When undefined, those ports, the CNT_W
//   parameter and all counter logic are absent; the datapath is identical.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      din/rnd_mode valid
//   in_ready   out  1      unit accepts din this cycle (combinational on out_ready)
//   din        in   IN_W   signed input sample
//   rnd_mode   in   1      0 = truncate (floor), 1 = round half up
//   out_valid  out  1      dout/sat_* valid
//   out_ready  in   1      downstream accepts dout
//   dout       out  OUT_W  signed resized result
//   sat_hi     out  1      result clipped to the most positive value
//   sat_lo     out  1      result clipped to the most negative value
//   sat_count  out  CNT_W  saturating count of clipped transfers (macro only)
//   cnt_clr    in   1      synchronous counter clear (macro only)
// ---------------------------------------------------------------------------
module truncador_pipe #(
  parameter int IN_W  = 32,
  parameter int IN_F  = 16,
  parameter int OUT_W = 16,
  parameter int OUT_F = 8
`ifdef TRUNC_SATCNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             sat_hi,
`ifdef TRUNC_SATCNT_EN
  output logic [CNT_W-1:0] sat_count,
  input  logic             cnt_clr,
`endif
  output logic             sat_lo
);

  localparam int SHIFT   = IN_F - OUT_F;
  localparam int EXT_W   = IN_W + 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Half an output LSB; zero when no bits are dropped so rounding is a no-op.
  localparam logic [EXT_W-1:0] RND_INC = (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : '0;

  // Output range limits, expressed at the widened stage-1 width.
  localparam logic signed [EXT_W-1:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    s1Valid_q, s1Valid_d;
  logic signed [EXT_W-1:0] s1Data_q, s1Data_d;
  logic                    outValid_q, outValid_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    satHi_q, satHi_d;
  logic                    satLo_q, satLo_d;

  logic                    inFire;
  logic                    s2Load;
  logic                    outFire;
  logic signed [EXT_W-1:0] extSample;
  logic signed [EXT_W-1:0] roundedSample;

  // Handshake network. Stage 2 (the output register) loads whenever stage 1
  // holds a sample and the output slot is empty or draining this cycle.
  // Stage 1 can then accept a new sample if it is empty or its sample moves
  // on, which makes in_ready combinational on out_ready.
  always_comb begin
    outFire  = outValid_q && out_ready;
    s2Load   = s1Valid_q && (!outValid_q || out_ready);
    in_ready = !s1Valid_q || s2Load;
    inFire   = in_valid && in_ready;
  end

  // Stage 1: sign-extend by one bit so the rounding carry cannot overflow,
  // add half an LSB when rounding, then drop the fractional bits with an
  // arithmetic shift (floor). rnd_mode is consumed here so it travels with
  // the sample it was presented with.
  always_comb begin
    extSample     = signed'({din[IN_W-1], din});
    roundedSample = extSample;
    if (rnd_mode) begin
      roundedSample = extSample + signed'(RND_INC);
    end

    s1Data_d = s1Data_q;
    if (inFire) begin
      s1Data_d = roundedSample >>> SHIFT;
    end

    s1Valid_d = s1Valid_q;
    if (inFire) begin
      s1Valid_d = 1'b1;
    end else if (s2Load) begin
      s1Valid_d = 1'b0;
    end
  end

  // Stage 2: clip the shifted value into the output range. A rounding carry
  // that lands just above the positive limit is caught here as well. The
  // output register only changes on s2Load, so a stalled result holds still.
  always_comb begin
    dout_d  = dout_q;
    satHi_d = satHi_q;
    satLo_d = satLo_q;
    if (s2Load) begin
      if (s1Data_q > MAX_V) begin
        dout_d  = OUT_MAX;
        satHi_d = 1'b1;
        satLo_d = 1'b0;
      end else if (s1Data_q < MIN_V) begin
        dout_d  = OUT_MIN;
        satHi_d = 1'b0;
        satLo_d = 1'b1;
      end else begin
        dout_d  = s1Data_q[OUT_W-1:0];
        satHi_d = 1'b0;
        satLo_d = 1'b0;
      end
    end

    outValid_d = outValid_q;
    if (s2Load) begin
      outValid_d = 1'b1;
    end else if (outFire) begin
      outValid_d = 1'b0;
    end
  end

  // Pipeline registers. Reset empties both stages at once so nothing that
  // was in flight ever reaches the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid_q  <= 1'b0;
      s1Data_q   <= '0;
      outValid_q <= 1'b0;
      dout_q     <= '0;
      satHi_q    <= 1'b0;
      satLo_q    <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Data_q   <= s1Data_d;
      outValid_q <= outValid_d;
      dout_q     <= dout_d;
      satHi_q    <= satHi_d;
      satLo_q    <= satLo_d;
    end
  end

  assign out_valid = outValid_q;
  assign dout      = dout_q;
  assign sat_hi    = satHi_q;
  assign sat_lo    = satLo_q;

`ifdef TRUNC_SATCNT_EN
  logic [CNT_W-1:0] satCount_q, satCount_d;

  // Saturation event counter. Counts clipped results as they leave the unit,
  // sticks at all-ones instead of wrapping, and a clear beats an increment
  // arriving in the same cycle.
  always_comb begin
    satCount_d = satCount_q;
    if (cnt_clr) begin
      satCount_d = '0;
    end else if (outFire && (satHi_q || satLo_q) && (satCount_q != {CNT_W{1'b1}})) begin
      satCount_d = satCount_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by the same asynchronous reset as the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      satCount_q <= '0;
    end else begin
      satCount_q <= satCount_d;
    end
  end

  assign sat_count = satCount_q;
`endif

endmodule

// File: tb/tb_truncador_pipe.sv
// ---------------------------------------------------------------------------
// tb_truncador_pipe
//
// Scoreboard bench for truncador_pipe at its default geometry
// (IN_W=32 IN_F=16 OUT_W=16 OUT_F=8). The stimulus side pushes the
// hand-computed {dout, sat_hi, sat_lo} for every accepted sample; a monitor
// pops and compares on every output transfer. Directed checks cover reset,
// latency, backpressure and mid-flight reset. With TRUNC_SATCNT_EN defined
// the DUT is built with CNT_W=2 and the saturation counter is exercised.
// ---------------------------------------------------------------------------
module tb_truncador_pipe;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
`ifdef TRUNC_SATCNT_EN
  localparam int CNT_W = 2;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  din;
  logic             rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dout;
  logic             sat_hi;
  logic             sat_lo;
`ifdef TRUNC_SATCNT_EN
  logic [CNT_W-1:0] sat_count;
  logic             cnt_clr;
`endif

  int checkCount = 0;
  int errorCount = 0;

  logic [OUT_W+1:0] expQ[$];

  // Directed vectors: din, rnd_mode, expected dout, sat_hi, sat_lo.
  localparam int NVEC = 11;
  logic [31:0]      vecDin  [NVEC] = '{32'h0000_0180, 32'h0100_0000, 32'hFF00_0000,
                                       32'h007F_FF80, 32'h007F_FF80, 32'hFFFF_FF80,
                                       32'hFFFF_FF80, 32'hFF80_0000, 32'hFF7F_FFFF,
                                       32'h0000_0080, 32'h007F_FF00};
  logic             vecRnd  [NVEC] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [OUT_W-1:0] vecDout [NVEC] = '{16'h0002, 16'h7FFF, 16'h8000, 16'h7FFF,
                                       16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000,
                                       16'h8000, 16'h0001, 16'h7FFF};
  logic             vecHi   [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic             vecLo   [NVEC] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  truncador_pipe #(
    .IN_W  (32),
    .IN_F  (16),
    .OUT_W (16),
    .OUT_F (8)
`ifdef TRUNC_SATCNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat_hi    (sat_hi),
`ifdef TRUNC_SATCNT_EN
    .sat_count (sat_count),
    .cnt_clr   (cnt_clr),
`endif
    .sat_lo    (sat_lo)
  );

  // 10 time-unit clock; the bench drives on the falling edge and samples
  // one unit before the rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one sample starting on a falling edge and hold it until the DUT
  // takes it; the expected result is queued when acceptance is seen.
  // Returns on the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [31:0] d, input logic rnd,
                               input logic [OUT_W-1:0] expD, input logic expHi,
                               input logic expLo);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    din      = d;
    rnd_mode = rnd;
    for (int t = 0; t < 200 && !accepted; t++) begin
      #4;
      if (in_ready) begin
        accepted = 1'b1;
        expQ.push_back({expD, expHi, expLo});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL accept_timeout: in_ready never rose for din 0x%0h", d);
    end
  endtask

  // Wait, bounded, until every queued expectation has been consumed.
  task automatic waitDrain();
    for (int t = 0; t < 100 && expQ.size() != 0; t++) begin
      @(negedge clk);
    end
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  // Monitor: on every output transfer pop the oldest expectation and compare.
  initial begin
    logic [OUT_W+1:0] expVal;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected_output: got 0x%0h with no sample pending", dout);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("scoreboard", {dout, sat_hi, sat_lo}, expVal);
        end
      end
    end
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    din       = '0;
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
`ifdef TRUNC_SATCNT_EN
    cnt_clr   = 1'b0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_dout", dout, 0);
    checkOutput("reset_flags", {sat_hi, sat_lo}, 0);
`ifdef TRUNC_SATCNT_EN
    checkOutput("reset_sat_count", sat_count, 0);
`endif
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    @(negedge clk);

    // Latency: presented before edge 1, captured at edge 1, out after edge 2.
    applyStimulus(32'h0000_0180, 1'b0, 16'h0001, 1'b0, 1'b0);
    #1;
    checkOutput("latency_early", out_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("latency_on_time", out_valid, 1);
    @(negedge clk);

    // Directed vectors, back to back, mixing rounding modes.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecDin[i], vecRnd[i], vecDout[i], vecHi[i], vecLo[i]);
    end
    waitDrain();

    // Backpressure: six samples while the output is stalled for four edges.
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus(32'h0000_0100 * (i + 1) + 32'h80, 1'(i & 1),
                        16'(i + 1 + (i & 1)), 1'b0, 1'b0);
        end
      end
      begin
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("bp_ready_one_held", in_ready, 1);
        @(negedge clk);
        #1;
        checkOutput("bp_ready_two_held", in_ready, 0);
        checkOutput("bp_valid_stalled", out_valid, 1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("bp_ready_still_low", in_ready, 0);
        checkOutput("bp_valid_held", out_valid, 1);
        checkOutput("bp_dout_held", dout, 16'h0001);
        out_ready = 1'b1;
        #3;
        for (int i = 0; i < 6; i++) begin
          if (i > 0) begin
            @(negedge clk);
            #4;
          end
          checkOutput("bp_burst_valid", out_valid, 1);
        end
      end
    join
    @(negedge clk);
    waitDrain();

    // Reset with both stages full: output clears at once, in-flight samples vanish.
    out_ready = 1'b0;
    applyStimulus(32'h0000_0300, 1'b0, 16'h0003, 1'b0, 1'b0);
    applyStimulus(32'h0000_0400, 1'b0, 16'h0004, 1'b0, 1'b0);
    #1;
    checkOutput("full_before_reset", out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_out_valid", out_valid, 0);
    checkOutput("mid_reset_dout", dout, 0);
    expQ.delete();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'h0000_0500, 1'b0, 16'h0005, 1'b0, 1'b0);
    waitDrain();

`ifdef TRUNC_SATCNT_EN
    // Counter: five clipped transfers stick at 3 with CNT_W=2.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0100_0000, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    end
    waitDrain();
    checkOutput("satcnt_saturated", sat_count, 3);

    // Clear coinciding with a clipped transfer wins.
    out_ready = 1'b0;
    applyStimulus(32'hFF00_0000, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    checkOutput("satcnt_clear_wins", sat_count, 0);
    @(negedge clk);

    // Counting resumes after the clear.
    applyStimulus(32'h0100_0000, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    waitDrain();
    checkOutput("satcnt_after_clear", sat_count, 1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
